// File: rtl/mmio_bridge_if.sv
// CPU data-path and device-side signals of the memory/IO bridge.
// slave: the bridge. master: the CPU/device environment.
interface mmio_bridge_if #(
   parameter int NUM_DEV   = 8,
   parameter int IO_WIDTH  = 16,
   parameter int SPAN_LOG2 = 4
);
   logic [31:0]                  Address;
   logic                         Memory_read;
   logic                         Memory_write;
   logic                         IO_read;
   logic                         IO_write;
   logic                         Memory_sign;
   logic [1:0]                   Memory_data_width;
   logic [31:0]                  Write_data_in;
   logic [31:0]                  Memory_read_data;
   logic [NUM_DEV*IO_WIDTH-1:0]  IO_read_data;
   logic [NUM_DEV-1:0]           Dev_ready;

   // Handshake: the CPU holds IO_read/IO_write and Address steady while Stall
   // is high. A device access is in flight while Dev_sel is nonzero; the
   // selected device completes it by raising its Dev_ready bit in any such
   // cycle, and its slice of IO_read_data is taken in that same cycle.
   logic [NUM_DEV-1:0]           Dev_sel;
   logic                         Dev_rd;
   logic                         Dev_wr;
   logic [SPAN_LOG2-1:0]         Dev_offset;
   logic [31:0]                  Write_data_latch;
   logic [31:0]                  Read_data;
   logic                         Stall;
   logic                         Bus_error;
   logic [31:0]                  Error_addr;

   modport slave (
      input  Address, Memory_read, Memory_write, IO_read, IO_write, Memory_sign,
             Memory_data_width, Write_data_in, Memory_read_data, IO_read_data,
             Dev_ready,
      output Dev_sel, Dev_rd, Dev_wr, Dev_offset, Write_data_latch, Read_data,
             Stall, Bus_error, Error_addr
   );

   modport master (
      output Address, Memory_read, Memory_write, IO_read, IO_write, Memory_sign,
             Memory_data_width, Write_data_in, Memory_read_data, IO_read_data,
             Dev_ready,
      input  Dev_sel, Dev_rd, Dev_wr, Dev_offset, Write_data_latch, Read_data,
             Stall, Bus_error, Error_addr
   );
endinterface

// File: rtl/mmio_bridge.sv
// Memory/IO bridge: decodes fixed-stride device windows, runs the IO
// ready/timeout handshake and lane-selects/extends load data.
module mmio_bridge #(
   parameter int          NUM_DEV   = 8,
   parameter logic [31:0] IO_BASE   = 32'hFFFFFC00,
   parameter int          SPAN_LOG2 = 4,
   parameter int          IO_WIDTH  = 16,
   parameter int          TIMEOUT   = 15
) (
   input  logic             Clock,
   input  logic             Reset,
   mmio_bridge_if.slave     bus,
   output logic [1:0]       fsm_state
);

   localparam int          IDX_W    = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
   localparam logic [7:0]  LAST_CNT = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERROR  = 2'd3
   } state_t;

   state_t state;

   function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] lane,
                                          input logic [1:0] width, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = lane[1] ? d[31:16] : d[15:0];
      case (width)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         default: r = d;
      endcase
      return r;
   endfunction

   // Request decode, evaluated only while IDLE
   logic             io_req, illegal, hit, aligned, legal;
   logic [31:0]      io_off, win;
   logic [IDX_W-1:0] dec_idx;

   always_comb begin
      io_req  = bus.IO_read | bus.IO_write;
      illegal = (bus.IO_read & bus.IO_write) |
                (io_req & (bus.Memory_read | bus.Memory_write));
      io_off  = bus.Address - IO_BASE;
      win     = io_off >> SPAN_LOG2;
      dec_idx = win[IDX_W-1:0];
      hit     = (bus.Address >= IO_BASE) && (win < 32'(NUM_DEV));
      case (bus.Memory_data_width)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~bus.Address[0];
         default: aligned = (bus.Address[1:0] == 2'b00);
      endcase
      legal = hit & aligned & ~illegal;
   end

   // Latched request and registered outputs
   logic [IDX_W-1:0]     idx_q;
   logic [1:0]           lane_q, width_q;
   logic                 sign_q;
   logic [31:0]          addr_q, wdata_q, rdata_q, eaddr_q;
   logic [7:0]           cnt_q;
   logic [NUM_DEV-1:0]   sel_q;
   logic                 dev_rd_q, dev_wr_q, stall_q, berr_q;
   logic [SPAN_LOG2-1:0] off_q;

   logic [IO_WIDTH-1:0]  io_slice;
   logic [31:0]          io_zx;

   // Device data is zero-extended to 32 bits before lane selection
   always_comb begin
      io_slice                = bus.IO_read_data[int'(idx_q)*IO_WIDTH +: IO_WIDTH];
      io_zx                   = '0;
      io_zx[IO_WIDTH-1:0]     = io_slice;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state    <= IDLE;
         idx_q    <= '0;
         lane_q   <= '0;
         width_q  <= '0;
         sign_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         eaddr_q  <= '0;
         cnt_q    <= '0;
         sel_q    <= '0;
         dev_rd_q <= 1'b0;
         dev_wr_q <= 1'b0;
         off_q    <= '0;
         stall_q  <= 1'b0;
         berr_q   <= 1'b0;
      end else begin
         berr_q <= 1'b0;
         case (state)
            IDLE: begin
               if (io_req) begin
                  addr_q <= bus.Address;
                  if (legal) begin
                     state    <= ACCESS;
                     idx_q    <= dec_idx;
                     sel_q    <= NUM_DEV'(1) << dec_idx;
                     dev_rd_q <= bus.IO_read;
                     dev_wr_q <= bus.IO_write;
                     off_q    <= io_off[SPAN_LOG2-1:0];
                     wdata_q  <= bus.IO_write ? bus.Write_data_in : 32'd0;
                     lane_q   <= bus.Address[1:0];
                     width_q  <= bus.Memory_data_width;
                     sign_q   <= bus.Memory_sign;
                     cnt_q    <= '0;
                     stall_q  <= 1'b1;
                  end else begin
                     state   <= ERROR;
                     berr_q  <= 1'b1;
                     eaddr_q <= bus.Address;
                  end
               end
            end
            ACCESS: begin
               // Ready wins over timeout when both land on the last cycle
               if (bus.Dev_ready[idx_q] || cnt_q == LAST_CNT) begin
                  if (bus.Dev_ready[idx_q]) begin
                     state   <= DONE;
                     rdata_q <= dev_rd_q ? extend(io_zx, lane_q, width_q, sign_q) : 32'd0;
                  end else begin
                     state   <= ERROR;
                     berr_q  <= 1'b1;
                     eaddr_q <= addr_q;
                  end
                  sel_q    <= '0;
                  dev_rd_q <= 1'b0;
                  dev_wr_q <= 1'b0;
                  off_q    <= '0;
                  wdata_q  <= '0;
                  stall_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.Dev_sel    = sel_q;
      bus.Dev_rd     = dev_rd_q;
      bus.Dev_wr     = dev_wr_q;
      bus.Dev_offset = off_q;
      bus.Bus_error  = berr_q;
      bus.Error_addr = eaddr_q;
      bus.Stall      = stall_q | (Reset & (state == IDLE) & io_req);
      if (state == ACCESS)
         bus.Write_data_latch = wdata_q;
      else
         bus.Write_data_latch = bus.Memory_write ? bus.Write_data_in : 32'd0;
      case (state)
         DONE:    bus.Read_data = rdata_q;
         ERROR:   bus.Read_data = 32'd0;
         default: bus.Read_data = bus.Memory_read ?
                                  extend(bus.Memory_read_data, bus.Address[1:0],
                                         bus.Memory_data_width, bus.Memory_sign) : 32'd0;
      endcase
      fsm_state = state;
   end

endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: a cycle-level expectation model fed by directed
// transactions, one compare process, and literal checks on key results.
module tb_mmio_bridge;
  localparam int          NUM_DEV   = 8;
  localparam int          IO_WIDTH  = 16;
  localparam int          SPAN_LOG2 = 4;
  localparam int          TIMEOUT   = 15;
  localparam logic [31:0] IO_BASE   = 32'hFFFFFC00;

  // clock / reset
  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [1:0] fsm_state;
  always #5 Clock = ~Clock;

  mmio_bridge_if #(.NUM_DEV(NUM_DEV), .IO_WIDTH(IO_WIDTH), .SPAN_LOG2(SPAN_LOG2)) bus ();

  mmio_bridge #(
    .NUM_DEV(NUM_DEV), .IO_BASE(IO_BASE), .SPAN_LOG2(SPAN_LOG2),
    .IO_WIDTH(IO_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus), .fsm_state(fsm_state)
  );

  typedef struct packed {
    logic [7:0]  sel;
    logic        rd;
    logic        wr;
    logic [3:0]  off;
    logic [31:0] wdl;
    logic [31:0] rdata;
    logic        stall;
    logic        berr;
    logic [31:0] eaddr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          stall_cnt = 0;
  int          acc_cnt = 0;
  logic [31:0] last_err = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  // Spec-level load extension: shift the lane down, mask, optionally sign-fill
  function automatic logic [31:0] m_ext(input logic [31:0] d, input logic [31:0] a,
                                        input logic [1:0] w, input logic s);
    int          sh;
    logic [31:0] mask, v;
    if (w == 2'b00) begin
      sh = int'(a % 32'd4) * 8;  mask = 32'h000000FF;
    end else if (w == 2'b01) begin
      sh = int'((a / 32'd2) % 32'd2) * 16;  mask = 32'h0000FFFF;
    end else begin
      sh = 0;  mask = 32'hFFFFFFFF;
    end
    v = (d >> sh) & mask;
    if (s && !w[1] && ((v & ~(mask >> 1)) != 32'd0)) v = v | ~mask;
    return v;
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e       = '0;
    e.eaddr = last_err;
    return e;
  endfunction

  // compare process
  always @(negedge Clock) begin
    if (Reset) begin
      if (bus.Stall) stall_cnt++;
      if (bus.Dev_sel != '0) acc_cnt++;
    end
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("dev_sel",    32'(bus.Dev_sel),    32'(cur.sel));
      chk("dev_rd",     32'(bus.Dev_rd),     32'(cur.rd));
      chk("dev_wr",     32'(bus.Dev_wr),     32'(cur.wr));
      chk("dev_offset", 32'(bus.Dev_offset), 32'(cur.off));
      chk("wdata",      bus.Write_data_latch, cur.wdl);
      chk("read_data",  bus.Read_data,       cur.rdata);
      chk("stall",      32'(bus.Stall),      32'(cur.stall));
      chk("bus_error",  32'(bus.Bus_error),  32'(cur.berr));
      chk("error_addr", bus.Error_addr,      cur.eaddr);
    end
  end

  // driver tasks
  task automatic set_idle();
    bus.Address = '0;  bus.Memory_read = 1'b0;  bus.Memory_write = 1'b0;
    bus.IO_read = 1'b0;  bus.IO_write = 1'b0;  bus.Memory_sign = 1'b0;
    bus.Memory_data_width = 2'b00;  bus.Write_data_in = '0;
    bus.Memory_read_data = '0;  bus.IO_read_data = '0;  bus.Dev_ready = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clock); #1;
      set_idle();
      exp_q.push_back(blank());
    end
  endtask

  task automatic mem_op(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [1:0] w, input logic sgn, input logic [31:0] mdata,
                        input logic [31:0] wdata, input logic [31:0] lit);
    exp_t e;
    @(posedge Clock); #1;
    set_idle();
    bus.Address = addr;  bus.Memory_read = rd;  bus.Memory_write = wr;
    bus.Memory_data_width = w;  bus.Memory_sign = sgn;
    bus.Memory_read_data = mdata;  bus.Write_data_in = wdata;
    stall_cnt = 0;
    e = blank();
    e.rdata = rd ? m_ext(mdata, addr, w, sgn) : 32'd0;
    e.wdl   = wr ? wdata : 32'd0;
    exp_q.push_back(e);
    @(negedge Clock); #1;
    chk(rd ? "mem_load_lit" : "mem_store_lit", rd ? bus.Read_data : bus.Write_data_latch, lit);
    chk("mem_stall_cycles", 32'(stall_cnt), 32'd0);
  endtask

  // delay = ACCESS cycles before ready (negative: never ready)
  task automatic io_txn(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic mem_too, input logic [1:0] w, input logic sgn,
                        input logic [31:0] wdata, input logic [15:0] ddata, input int delay,
                        input int lit_stall, input int lit_acc, input logic [31:0] lit_rdata);
    exp_t        e;
    logic [31:0] off;
    int          dev;
    logic        hit, al, legal, ok;
    off   = addr - IO_BASE;
    hit   = (addr >= IO_BASE) && (off < 32'(NUM_DEV * 16));
    dev   = hit ? int'(off / 32'd16) : 0;
    al    = (w == 2'b00) || (w == 2'b01 && addr % 32'd2 == 32'd0) ||
            (w[1] && addr % 32'd4 == 32'd0);
    legal = hit && al && !(rd && wr) && !mem_too;

    @(posedge Clock); #1;
    set_idle();
    bus.Address = addr;  bus.IO_read = rd;  bus.IO_write = wr;  bus.Memory_read = mem_too;
    bus.Memory_data_width = w;  bus.Memory_sign = sgn;  bus.Write_data_in = wdata;
    for (int j = 0; j < NUM_DEV; j++)
      bus.IO_read_data[j*IO_WIDTH +: IO_WIDTH] = (j == dev) ? ddata : (16'h5A00 | 16'(j));
    bus.Dev_ready = '1;
    stall_cnt = 0;
    acc_cnt   = 0;
    e = blank();
    e.stall = 1'b1;
    exp_q.push_back(e);

    ok = 1'b0;
    if (legal) begin
      for (int k = 0; k < TIMEOUT; k++) begin
        @(posedge Clock); #1;
        bus.Dev_ready = (k == delay) ? (NUM_DEV'(1) << dev) : ~(NUM_DEV'(1) << dev);
        e = blank();
        e.sel = 8'(1) << dev;  e.rd = rd;  e.wr = wr;
        e.off = 4'(addr % 32'd16);  e.wdl = wr ? wdata : 32'd0;  e.stall = 1'b1;
        exp_q.push_back(e);
        if (k == delay) begin
          ok = 1'b1;
          break;
        end
      end
    end
    @(posedge Clock); #1;
    bus.Dev_ready = '0;
    if (ok) begin
      e = blank();
      e.rdata = rd ? m_ext(32'(ddata), addr, w, sgn) : 32'd0;
    end else begin
      last_err = addr;
      e = blank();
      e.berr = 1'b1;
    end
    exp_q.push_back(e);
    @(negedge Clock); #1;
    chk("stall_cycles",  32'(stall_cnt), 32'(lit_stall));
    chk("access_cycles", 32'(acc_cnt),   32'(lit_acc));
    chk("final_rdata",   bus.Read_data,  lit_rdata);
  endtask

  initial begin
    exp_t e;
    set_idle();
    idle(2);
    @(negedge Clock);
    Reset = 1'b1;
    idle(1);

    // memory path: no stall, combinational extension
    mem_op(32'h00001002, 1'b1, 1'b0, 2'b01, 1'b1, 32'h80011234, 32'd0, 32'hFFFF8001);
    mem_op(32'h00002003, 1'b1, 1'b0, 2'b00, 1'b0, 32'h80011234, 32'd0, 32'h00000080);
    mem_op(32'h00002001, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000F200, 32'd0, 32'hFFFFFFF2);
    mem_op(32'h00002000, 1'b1, 1'b0, 2'b01, 1'b0, 32'h80011234, 32'd0, 32'h00001234);
    mem_op(32'h00002000, 1'b1, 1'b0, 2'b10, 1'b1, 32'h80011234, 32'd0, 32'h80011234);
    mem_op(32'h00003000, 1'b0, 1'b1, 2'b10, 1'b0, 32'd0, 32'hCAFEBABE, 32'hCAFEBABE);

    // IO transactions, chained back to back
    io_txn(32'hFFFFFC70, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'd0, 16'hA5F0, 0, 2, 1, 32'h0000A5F0);
    io_txn(32'hFFFFFC20, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h00001234, 16'h0000, 3, 5, 4, 32'd0);
    io_txn(32'hFFFFFC30, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 16'h1111, -1, 16, 15, 32'd0);
    chk("timeout_err_addr", bus.Error_addr, 32'hFFFFFC30);
    io_txn(32'hFFFFFC80, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 16'h2222, 0, 1, 0, 32'd0);
    io_txn(32'hFFFFFC02, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 16'h3333, 0, 1, 0, 32'd0);
    io_txn(32'hFFFFFC51, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'd0, 16'h9A00, TIMEOUT - 1, 16, 15,
           32'hFFFFFF9A);
    io_txn(32'hFFFFFC4D, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h000000AB, 16'h0000, 2, 4, 3, 32'd0);
    io_txn(32'hFFFFFC00, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 16'h4444, 0, 1, 0, 32'd0);
    io_txn(32'hFFFFFC00, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'd0, 16'h4444, 0, 1, 0, 32'd0);
    io_txn(32'hFFFFFBF0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 16'h5555, 0, 1, 0, 32'd0);
    chk("below_base_err_addr", bus.Error_addr, 32'hFFFFFBF0);
    io_txn(32'hFFFFFC72, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'd0, 16'h8001, 0, 2, 1, 32'd0);

    // reset dropped in the middle of an ACCESS phase
    @(posedge Clock); #1;
    set_idle();
    bus.Address = 32'hFFFFFC30;  bus.IO_read = 1'b1;  bus.Memory_data_width = 2'b01;
    e = blank();  e.stall = 1'b1;
    exp_q.push_back(e);
    repeat (2) begin
      @(posedge Clock); #1;
      e = blank();  e.sel = 8'h08;  e.rd = 1'b1;  e.stall = 1'b1;
      exp_q.push_back(e);
    end
    @(posedge Clock); #2;
    Reset = 1'b0;
    #1;
    chk("rst_dev_sel",    32'(bus.Dev_sel),    32'd0);
    chk("rst_dev_rd",     32'(bus.Dev_rd),     32'd0);
    chk("rst_stall",      32'(bus.Stall),      32'd0);
    chk("rst_bus_error",  32'(bus.Bus_error),  32'd0);
    chk("rst_error_addr", bus.Error_addr,      32'd0);
    chk("rst_read_data",  bus.Read_data,       32'd0);
    chk("rst_wdata",      bus.Write_data_latch, 32'd0);
    chk("rst_offset",     32'(bus.Dev_offset), 32'd0);
    set_idle();
    last_err = 32'd0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    io_txn(32'hFFFFFC10, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'd0, 16'h8765, 1, 3, 2, 32'hFFFF8765);

    idle(2);
    @(negedge Clock); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Parametrised memory/IO bridge between the CPU data path and the memory-mapped peripherals. It decodes `NUM_DEV` fixed-stride device windows and drives a one-hot chip select to the addressed device. IO accesses run through a ready/timeout handshake that stalls the CPU, and accesses to no device or with bad alignment are reported as bus errors. Memory and IO read data are lane-selected and sign- or zero-extended per access width.

## Interface
- `NUM_DEV`, 8: number of device windows (1..16)
- `IO_BASE`, 32'hFFFFFC00: base address of device 0
- `SPAN_LOG2`, 4: log2 of the window size in bytes. Device i occupies `IO_BASE + i<<SPAN_LOG2`.
- `IO_WIDTH`, 16: device data width (8..32)
- `TIMEOUT`, 15: maximum ACCESS cycles without `Dev_ready` (1..255)

- `Clock`  in  1  system clock, rising edge
- `Reset`  in  1  asynchronous, active-low
- `Address`  in  32  CPU data address
- `Memory_read`, `Memory_write`, `IO_read`, `IO_write`  in  1 each  control-unit strobes
- `Memory_sign`  in  1  1 = sign-extend sub-word reads
- `Memory_data_width`  in  2  00 byte, 01 half, 1x word
- `Write_data_in`  in  32  store data from the CPU
- `Memory_read_data`  in  32  data RAM output
- `IO_read_data`  in  NUM_DEV*IO_WIDTH  device i data on slice i
- `Dev_ready`  in  NUM_DEV  device i has completed its access
- `Dev_sel`  out  NUM_DEV  one-hot chip select
- `Dev_rd`, `Dev_wr`  out  1 each  IO direction, valid while `Dev_sel` is nonzero
- `Dev_offset`  out  SPAN_LOG2  byte offset within the window
- `Write_data_latch`  out  32  store data to RAM or device
- `Read_data`  out  32  extended load result
- `Stall`  out  1  CPU hold request
- `Bus_error`  out  1  one-cycle error pulse
- `Error_addr`  out  32  address of the last error

## Operation
- **FSM states:** IDLE, ACCESS, DONE, ERROR. Reset puts the FSM in IDLE.
- **Memory path** (combinational, no FSM involvement):
  - `Read_data` = extend(`Memory_read_data`).
  - `Write_data_latch` = `Write_data_in` during `Memory_write`.
- **Extension rules:**
  - Byte access: the lane is `Address[1:0]`.
  - Half access: the lane is `Address[1]`.
  - Sign or zero extension follows `Memory_sign`.
  - IO data is first zero-extended from `IO_WIDTH` to 32 bits, then lane-selected.
- **IDLE:**
  - With an IO request, decode it.
  - If `Address` hits window i and the access is aligned (half: `Address[0]`=0; word: `Address[1:0]`=0), latch i, offset, direction and write data, then go to ACCESS.
  - Otherwise go to ERROR.
- **Illegal strobe combinations go to ERROR** with no device select:
  - `IO_read` together with `IO_write`.
  - Any IO strobe together with any Memory strobe.
- **ACCESS:**
  - `Dev_sel`[i], `Dev_rd`/`Dev_wr`, `Dev_offset` and `Write_data_latch` are driven from the latched values.
  - The wait counter starts at 0 on entry and increments each cycle.
  - If `Dev_ready`[i]=1, capture extend(slice i) into the read register and go to DONE.
  - Otherwise, if counter = `TIMEOUT`-1, go to ERROR.
- **DONE:** `Read_data` = read register (0 for writes). Then go to IDLE.
- **ERROR:**
  - `Bus_error`=1.
  - `Error_addr` is loaded with the request address.
  - `Read_data`=0.
  - Then go to IDLE.
- **Stall:**
  - High in IDLE when an IO request is present.
  - High in every ACCESS cycle.
  - Low in DONE and ERROR, so the CPU advances at the end of those cycles.
- **Decode:** `Address` < `IO_BASE`, or device index ≥ `NUM_DEV`, is a miss.
- **No tristates:** `Write_data_latch` is 0 when there is no write.

## Timing
- **Reset values:** `Dev_sel`=0, `Dev_rd`/`Dev_wr`=0, `Dev_offset`=0, `Read_data`=0, `Write_data_latch`=0, `Stall`=0, `Bus_error`=0, `Error_addr`=0.
- **Reset mid-access** aborts immediately: select drops asynchronously and no error is reported.
- **Memory access:** 0 extra cycles.
- **IO access with ready on the first ACCESS cycle:**
  - Cycle 0 IDLE (stall), cycle 1 ACCESS (stall), cycle 2 DONE (data valid, stall low).
  - Stall total is 2 cycles. Each cycle of ready delay adds 1.
- **Timeout:** ERROR is reached after exactly `TIMEOUT` ACCESS cycles.
- **Ready timing:**
  - `Dev_ready` is sampled only in ACCESS, and only bit i is observed.
  - Ready arriving on the same cycle as the final timeout cycle counts as success.
- **Back-to-back requests:** an IO request in the cycle after DONE or ERROR starts a new decode. There is no dead cycle beyond IDLE.
- **Write data:** `Dev_wr` and the write data are stable for the whole ACCESS phase.

## Test plan
- Load halfword, signed, from RAM at `Address[1]`=1 with data 32'h8001_1234 -> `Read_data` = 32'hFFFF8001, `Stall` never high.
- `IO_read` at FFFFFC70 with device 7 ready immediately and data 16'hA5F0 -> `Dev_sel`=8'h80 for 1 cycle, `Read_data`=32'h0000A5F0 in DONE, `Stall` high 2 cycles.
- `IO_write` at FFFFFC20 of 32'h1234 with ready delayed 3 cycles -> `Dev_wr`=1 and `Write_data_latch`=32'h1234 for 4 ACCESS cycles, `Stall` high 5 cycles.
- `IO_read` at FFFFFC30 with ready never asserted, `TIMEOUT`=15 -> 15 ACCESS cycles, then `Bus_error` pulse, `Error_addr`=FFFFFC30, `Read_data`=0.
- `IO_read` at FFFFFC80 (`NUM_DEV`=8), and separately a misaligned word IO read at FFFFFC02 -> immediate ERROR, `Dev_sel` stays 0.
- Reset dropped during ACCESS -> all outputs 0 asynchronously; after release, an immediate IO read completes normally.
